// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: N-digit multiplexed 7-segment driver with sequential binary-to-BCD load.
// Optional SEG_DP_EN adds a decimal-point position input and active-low dp output.
module seg_display_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int SCAN_DIV   = 200000,
    parameter int BLINK_DIV  = 25000000,
    parameter int LZ_BLANK   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [VALUE_W-1:0]            value,
    input  logic                          value_valid,
    output logic                          value_ready,
    input  logic [1:0]                    mode,
    input  logic                          blink,
`ifdef SEG_DP_EN
    input  logic [$clog2(NUM_DIGITS)-1:0] dp_pos,
    output logic                          dp,
`endif
    output logic [6:0]                    seg,
    output logic [NUM_DIGITS-1:0]         an
);
    localparam int BW = NUM_DIGITS * 4;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(VALUE_W + 1);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int KW = $clog2(BLINK_DIV);
    localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIGITS) - 64'd1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    state_t state, state_nx;

    logic                  accept;
    logic [CW-1:0]         cnt;
    logic [VALUE_W-1:0]    bin;
    logic [BW-1:0]         bcd, bcd_adj, disp;
    logic                  ovf_pend, ovf;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         idx;
    logic [KW-1:0]         blink_cnt;
    logic                  phase, hidden, lz_ok, blank_lz, run;
    logic [NUM_DIGITS-1:0] lz;
    logic [3:0]            nib;
    logic [6:0]            glyph;

    function automatic logic [6:0] dec_glyph(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0011000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] word_glyph(input logic [1:0] m, input int p);
        if (p > 3) return 7'h7F;
        case ({m, 2'(p)})
            4'b01_00: return 7'b0000110;
            4'b01_01: return 7'b0001000;
            4'b01_10: return 7'b0010010;
            4'b01_11: return 7'b0010001;
            4'b10_00: return 7'b0101111;
            4'b10_01: return 7'b0000110;
            4'b10_10: return 7'b0010000;
            4'b10_11: return 7'b1000001;
            4'b11_00: return 7'b0001001;
            4'b11_01: return 7'b0001000;
            4'b11_10: return 7'b0101111;
            4'b11_11: return 7'b0100001;
            default:  return 7'h7F;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        value_ready = (state == IDLE);
        accept      = value_valid && value_ready;
        state_nx    = state == IDLE  ? (accept ? SHIFT : IDLE) :
                      state == SHIFT ? (cnt == CW'(VALUE_W - 1) ? COMMIT : SHIFT) : IDLE;
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // Carries out of the top nibble are dropped; they only occur for overflowed values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            bin      <= '0;
            bcd      <= '0;
            disp     <= '0;
            ovf_pend <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (accept) begin
                bin      <= value;
                bcd      <= '0;
                cnt      <= '0;
                ovf_pend <= 64'(value) > MAX_VAL;
            end
            if (state == SHIFT) begin
                {bcd, bin} <= {bcd_adj, bin} << 1;
                cnt        <= cnt + 1'b1;
            end
            if (state == COMMIT) begin
                disp <= bcd;
                ovf  <= ovf_pend;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            scan_cnt  <= scan_cnt == SW'(SCAN_DIV - 1) ? '0 : scan_cnt + 1'b1;
            blink_cnt <= blink_cnt == KW'(BLINK_DIV - 1) ? '0 : blink_cnt + 1'b1;
            if (scan_cnt == SW'(SCAN_DIV - 1))
                idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
            if (blink_cnt == KW'(BLINK_DIV - 1))
                phase <= ~phase;
        end
    end

`ifdef SEG_DP_EN
    assign lz_ok = idx < dp_pos;
`else
    assign lz_ok = 1'b1;
`endif

    // lz[i]: every nibble from the leftmost position through position i is zero.
    always_comb begin
        run = 1'b1;
        lz  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            run   = run && (disp[(NUM_DIGITS-1-i)*4 +: 4] == 4'd0);
            lz[i] = run;
        end
        nib      = disp[(NUM_DIGITS-1-int'(idx))*4 +: 4];
        hidden   = blink && phase;
        blank_lz = (LZ_BLANK != 0) && lz[idx] && (idx != IW'(NUM_DIGITS - 1)) && lz_ok;
        glyph    = hidden     ? 7'h7F :
                   mode != 0  ? word_glyph(mode, int'(idx)) :
                   ovf        ? 7'b0111111 :
                   blank_lz   ? 7'h7F : dec_glyph(nib);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= 7'h7F;
            an  <= '1;
        end else begin
            seg <= glyph;
            an  <= ~(NUM_DIGITS'(1) << idx);
        end
    end

`ifdef SEG_DP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dp <= 1'b1;
        else     dp <= !(idx == dp_pos && mode == 2'd0 && !ovf && !hidden);
    end
`endif

endmodule
